id_ctrl: RTL and testbench

ID_CTRL -- requirements
Module: id_ctrl

---
 rtl/id_ctrl.sv | 153 +++++++++++++++
 tb/tb_id_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ctrl.sv
// id_ctrl: single-entry IF/ID pipeline register with instruction decode,
// load-use hazard detection and a saturating stall counter.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   if_valid, if_instr, if_pc   fetch handshake and payload
//   id_ready                    entry can accept a fetch this cycle
//   ex_ready                    execute accepts the decode output
//   flush                       taken branch/jump in EX; kill ID contents
//   ex_memread, ex_rd           load in EX and its destination register
//   id_valid                    decode output valid toward EX
//   id_pc, id_imm, id_immsrc    held PC, instr[31:7], immediate format
//   id_rs1, id_rs2, id_rd       register fields of the held instruction
//   id_illegal                  held opcode not recognised
//   stall_count                 saturating count of load-use stall cycles
//
// state  | meaning
// EMPTY  | no instruction held; accept fetch
// FULL   | instruction held, no hazard; offer to EX
// HAZARD | instruction held, load-use conflict; present bubble, hold entry
module id_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        id_ready,
  input  logic        ex_ready,
  input  logic        flush,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [24:0] id_imm,
  output logic [2:0]  id_immsrc,
  output logic [4:0]  id_rs1,
  output logic [4:0]  id_rs2,
  output logic [4:0]  id_rd,
  output logic        id_illegal,
  output logic [15:0] stall_count
);

  localparam logic [1:0] EMPTY  = 2'd0;
  localparam logic [1:0] FULL   = 2'd1;
  localparam logic [1:0] HAZARD = 2'd2;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  logic        entry_valid;
  logic [31:0] entry_instr;
  logic [31:0] entry_pc;

  logic [2:0]  dec_immsrc;
  logic        dec_use_rs1;
  logic        dec_use_rs2;
  logic        dec_illegal;
  logic        hazard;
  logic [1:0]  state;
  logic        transfer;
  logic        load;
  logic        show;

  always_comb begin
    dec_immsrc  = IMM_I;
    dec_use_rs1 = 1'b0;
    dec_use_rs2 = 1'b0;
    dec_illegal = 1'b0;
    case (entry_instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111,
      7'b1110011, 7'b0001111: begin
        dec_immsrc  = IMM_I;
        dec_use_rs1 = 1'b1;
      end
      7'b0100011: begin
        dec_immsrc  = IMM_S;
        dec_use_rs1 = 1'b1;
        dec_use_rs2 = 1'b1;
      end
      7'b1100011: begin
        dec_immsrc  = IMM_B;
        dec_use_rs1 = 1'b1;
        dec_use_rs2 = 1'b1;
      end
      7'b1101111: dec_immsrc = IMM_J;
      7'b0110111, 7'b0010111: dec_immsrc = IMM_U;
      7'b0110011: begin
        dec_immsrc  = IMM_I;
        dec_use_rs1 = 1'b1;
        dec_use_rs2 = 1'b1;
      end
      // unknown opcodes read no registers, so they never cause a stall
      default: dec_illegal = 1'b1;
    endcase
  end

  assign hazard = entry_valid && ex_memread && (ex_rd != 5'd0) &&
                  ((dec_use_rs1 && (entry_instr[19:15] == ex_rd)) ||
                   (dec_use_rs2 && (entry_instr[24:20] == ex_rd)));

  // State is a pure function of the held entry and the EX-side hazard inputs,
  // so it is derived rather than stored; the entry valid bit is the only flop.
  always_comb begin
    if (!entry_valid)  state = EMPTY;
    else if (hazard)   state = HAZARD;
    else               state = FULL;
  end

  assign id_valid = rst_n && !flush && (state == FULL);
  assign transfer = id_valid && ex_ready;
  assign id_ready = rst_n && !flush && ((state == EMPTY) || transfer);
  assign load     = if_valid && id_ready;

  // Outputs read as zero whenever nothing is held or reset is asserted.
  assign show       = entry_valid && rst_n;
  assign id_pc      = show ? entry_pc           : 32'h0;
  assign id_imm     = show ? entry_instr[31:7]  : 25'h0;
  assign id_immsrc  = show ? dec_immsrc         : 3'b000;
  assign id_rs1     = show ? entry_instr[19:15] : 5'd0;
  assign id_rs2     = show ? entry_instr[24:20] : 5'd0;
  assign id_rd      = show ? entry_instr[11:7]  : 5'd0;
  assign id_illegal = show && dec_illegal;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry_valid <= 1'b0;
      entry_instr <= 32'h0;
      entry_pc    <= 32'h0;
    end else if (flush) begin
      entry_valid <= 1'b0;
      entry_instr <= 32'h0;
      entry_pc    <= 32'h0;
    end else if (load) begin
      entry_valid <= 1'b1;
      entry_instr <= if_instr;
      entry_pc    <= if_pc;
    end else if (transfer) begin
      entry_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count <= 16'h0;
    end else if ((state == HAZARD) && !flush && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_id_ctrl.sv
module tb_id_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        ex_ready;
  logic        flush;
  logic        ex_memread;
  logic [4:0]  ex_rd;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [24:0] id_imm;
  logic [2:0]  id_immsrc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_illegal;
  logic [15:0] stall_count;

  id_ctrl dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .id_ready(id_ready), .ex_ready(ex_ready), .flush(flush),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .id_valid(id_valid),
    .id_pc(id_pc), .id_imm(id_imm), .id_immsrc(id_immsrc), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_illegal(id_illegal),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [24:0] imm;
    logic [2:0]  immsrc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  // reference model state: what the IF/ID register should hold
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_pc    = 32'h0;
  logic [15:0] m_stall = 16'h0;

  localparam logic [31:0] ADDI = 32'h00A00093; // addi x1,x0,10
  localparam logic [31:0] SW   = 32'h0020A023; // sw x2,0(x1)
  localparam logic [31:0] BEQ  = 32'h00208063; // beq x1,x2,0
  localparam logic [31:0] JAL  = 32'h0000006F; // jal x0,0
  localparam logic [31:0] LUI5 = 32'h000012B7; // lui x5,1
  localparam logic [31:0] ADD  = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] ILL  = 32'h0000007F;

  // instruction format letter straight from the opcode table
  function automatic byte fmt(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0001111: return "I";
      7'b0100011: return "S";
      7'b1100011: return "B";
      7'b1101111: return "J";
      7'b0110111, 7'b0010111: return "U";
      7'b0110011: return "R";
      default:    return "X";
    endcase
  endfunction

  function automatic exp_t exp_of(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    byte f;
    f = fmt(ins[6:0]);
    e.pc  = pc;
    e.imm = ins[31:7];
    e.immsrc = (f == "S") ? 3'b001 : (f == "B") ? 3'b010 :
               (f == "J") ? 3'b011 : (f == "U") ? 3'b100 : 3'b000;
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd  = ins[11:7];
    e.ill = (f == "X");
    return e;
  endfunction

  function automatic bit reads_reg(input logic [31:0] ins, input logic [4:0] r);
    byte f;
    f = fmt(ins[6:0]);
    return ((f == "I" || f == "S" || f == "B" || f == "R") && ins[19:15] == r) ||
           ((f == "S" || f == "B" || f == "R") && ins[24:20] == r);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // one clock cycle of stimulus; checks this cycle's outputs against the model
  // and advances the model to the next cycle
  task automatic cyc(input logic r, input logic iv, input logic [31:0] ins,
                     input logic [31:0] pcv, input logic er, input logic fl,
                     input logic mr, input logic [4:0] rd);
    bit hz, e_valid, e_ready;
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; if_valid = iv; if_instr = ins; if_pc = pcv;
    ex_ready = er; flush = fl; ex_memread = mr; ex_rd = rd;
    hz = m_valid && mr && (rd != 0) && reads_reg(m_instr, rd);
    e_valid = r && !fl && m_valid && !hz;
    e_ready = r && !fl && (!m_valid || (e_valid && er));
    #3;
    chk("id_ready", 128'(id_ready), 128'(e_ready));
    chk("id_valid", 128'(id_valid), 128'(e_valid));
    chk("stall_count", 128'(stall_count), 128'(m_stall));
    e = (r && m_valid) ? exp_of(m_instr, m_pc) : '0;
    chk("decode", 128'({id_pc, id_imm, id_immsrc, id_rs1, id_rs2, id_rd, id_illegal}),
        128'(e));
    if (!r) begin
      if (m_valid) void'(sb.pop_back());
      m_valid = 1'b0;
      m_stall = 16'h0;
    end else if (fl) begin
      if (m_valid) void'(sb.pop_back());
      m_valid = 1'b0;
    end else begin
      if (m_valid && hz && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      if (iv && e_ready) begin
        m_valid = 1'b1; m_instr = ins; m_pc = pcv;
        sb.push_back(exp_of(ins, pcv));
      end else if (e_valid && er) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic idle(input logic er);
    cyc(1'b1, 1'b0, 32'h0, 32'h0, er, 1'b0, 1'b0, 5'd0);
  endtask

  // monitor: every transfer toward EX must match the oldest loaded instruction
  always @(negedge clk) begin
    exp_t e;
    if (id_valid === 1'b1 && ex_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL transfer: unexpected pc %0h with empty scoreboard", id_pc);
      end else begin
        e = sb.pop_front();
        if ({id_pc, id_imm, id_immsrc, id_rs1, id_rs2, id_rd, id_illegal} !== e) begin
          errors++;
          $display("FAIL transfer: got pc %0h imm %0h src %0h expected pc %0h imm %0h src %0h",
                   id_pc, id_imm, id_immsrc, e.pc, e.imm, e.immsrc);
        end
      end
    end
  end

  initial begin
    logic [31:0] rnd, ins;
    logic [6:0] ops [13];
    ops = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0001111,
            7'b0100011, 7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111,
            7'b0110011, 7'b1111111, 7'b0000000};
    rst_n = 1'b0; if_valid = 1'b1; if_instr = ADDI; if_pc = 32'h40;
    ex_ready = 1'b1; flush = 1'b0; ex_memread = 1'b0; ex_rd = 5'd0;

    repeat (3) cyc(1'b0, 1'b1, ADDI, 32'h40, 1'b1, 1'b0, 1'b0, 5'd0);

    // addi then empty
    cyc(1'b1, 1'b1, ADDI, 32'h100, 1'b1, 1'b0, 1'b0, 5'd0);
    idle(1'b1);
    idle(1'b1);

    // back-to-back stream of S/B/J/U formats
    cyc(1'b1, 1'b1, SW,   32'h200, 1'b1, 1'b0, 1'b0, 5'd0);
    cyc(1'b1, 1'b1, BEQ,  32'h204, 1'b1, 1'b0, 1'b0, 5'd0);
    chk("stream_sw", 128'(id_immsrc), 128'(3'b001));
    cyc(1'b1, 1'b1, JAL,  32'h208, 1'b1, 1'b0, 1'b0, 5'd0);
    chk("stream_beq", 128'(id_immsrc), 128'(3'b010));
    cyc(1'b1, 1'b1, LUI5, 32'h20C, 1'b1, 1'b0, 1'b0, 5'd0);
    chk("stream_jal", 128'(id_immsrc), 128'(3'b011));
    idle(1'b1);
    chk("stream_lui", 128'(id_immsrc), 128'(3'b100));

    // load-use hazard on rs2 for one cycle
    cyc(1'b1, 1'b1, ADD, 32'h300, 1'b1, 1'b0, 1'b0, 5'd0);
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd2);
    idle(1'b1);
    chk("hazard_count", 128'(stall_count), 128'(16'd1));

    // ex_rd = 0 and lui (no rs use) must not stall
    cyc(1'b1, 1'b1, ADD, 32'h310, 1'b1, 1'b0, 1'b0, 5'd0);
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd0);
    cyc(1'b1, 1'b1, LUI5, 32'h320, 1'b1, 1'b0, 1'b0, 5'd0);
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd5);
    idle(1'b1);

    // flush while full and stalled by EX, with a fetch offered
    cyc(1'b1, 1'b1, ADDI, 32'h400, 1'b0, 1'b0, 1'b0, 5'd0);
    cyc(1'b1, 1'b1, SW,   32'h404, 1'b0, 1'b1, 1'b0, 5'd0);
    idle(1'b1);

    // illegal opcode
    cyc(1'b1, 1'b1, ILL, 32'h500, 1'b1, 1'b0, 1'b0, 5'd0);
    idle(1'b1);

    // long hazard: counter must saturate
    cyc(1'b1, 1'b1, ADD, 32'h600, 1'b1, 1'b0, 1'b0, 5'd0);
    repeat (70000) cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd1);
    chk("stall_saturate", 128'(stall_count), 128'(16'hFFFF));
    // reset mid-hazard discards the entry; load right after reset releases
    cyc(1'b0, 1'b1, SW, 32'h700, 1'b1, 1'b0, 1'b1, 5'd1);
    cyc(1'b1, 1'b1, BEQ, 32'h704, 1'b1, 1'b0, 1'b0, 5'd0);
    idle(1'b1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rnd = $urandom();
      ins = {rnd[31:25], 3'(rnd[24:23]), rnd[19:18], 3'(rnd[17:16]), rnd[14:7],
             ops[$urandom_range(0, 12)]};
      cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 7), ins, $urandom(),
          ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 3)));
    end
    repeat (4) idle(1'b1);
    chk("scoreboard_drained", 128'(sb.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
